start_sequencer: RTL and testbench

- Multi-channel start/done sequencer for the ODE accelerator; the parametrised successor of the single-channel Euler start FSM.
- Each channel turns a level start request into one-cycle start pulses to a solver core. It waits for that core's final-done and can re-launch the core for a programmed number of iterations.
- Adds a per-channel watchdog timeout and a sticky error flag.
- Sits between the host control registers and the Euler/RK solver instances.

---
 rtl/start_seq_pkg.sv | 17 +
 rtl/start_sequencer_if.sv | 35 +++
 rtl/start_seq_channel.sv | 125 ++++++++++++
 rtl/start_sequencer.sv | 66 ++++++
 tb/tb_start_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/start_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// start_seq_pkg : shared state encoding and default widths for start_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package start_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int TMO_W_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/start_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// start_sequencer_if : host/solver-facing bundle of the multi-channel sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface start_sequencer_if
  import start_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) ();

  logic [NUM_CH-1:0] start_req;
  logic [CNT_W-1:0]  iter_count;
  logic [TMO_W-1:0]  tmo_limit;
  logic [NUM_CH-1:0] done_in;
  logic [NUM_CH-1:0] start_pulse;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done_pulse;
  logic [NUM_CH-1:0] tmo_err;
  logic              all_idle;

  modport master (
    output start_req, iter_count, tmo_limit, done_in,
    input  start_pulse, busy, done_pulse, tmo_err, all_idle
  );

  modport slave (
    input  start_req, iter_count, tmo_limit, done_in,
    output start_pulse, busy, done_pulse, tmo_err, all_idle
  );

endinterface
`default_nettype wire

// File: rtl/start_seq_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// start_seq_channel : one start/done FSM with iteration counter and watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
module start_seq_channel
  import start_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_async_n,
  input  logic             rst_sync,
  input  logic             i_start_req,
  input  logic [CNT_W-1:0] i_iter_count,
  input  logic [TMO_W-1:0] i_tmo_limit,
  input  logic             i_done_in,
  output logic             o_start_pulse,
  output logic             o_busy,
  output logic             o_busy_nxt,
  output logic             o_done_pulse,
  output logic             o_tmo_err
);

  localparam logic [CNT_W-1:0] c_iter_one  = CNT_W'(1);
  localparam logic [TMO_W-1:0] c_timer_one = TMO_W'(1);
  localparam logic [TMO_W-1:0] c_timer_max = '1;

  state_e           r_state, w_state_nxt;
  logic             r_start_pulse, w_start_pulse_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done_pulse, w_done_pulse_nxt;
  logic             r_tmo_err, w_tmo_err_nxt;
  logic [CNT_W-1:0] r_iter_left, w_iter_left_nxt;
  logic [TMO_W-1:0] r_timer, w_timer_nxt;
  logic             w_done_seen;
  logic             w_timeout;

  // A done coinciding with our own start pulse belongs to the previous launch.
  assign w_done_seen = i_done_in && !r_start_pulse;
  assign w_timeout   = (i_tmo_limit != '0) && (r_timer == (i_tmo_limit - c_timer_one));

  always_comb begin
    w_state_nxt       = r_state;
    w_start_pulse_nxt = 1'b0;
    w_busy_nxt        = r_busy;
    w_done_pulse_nxt  = 1'b0;
    w_tmo_err_nxt     = r_tmo_err;
    w_iter_left_nxt   = r_iter_left;
    w_timer_nxt       = r_timer;
    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (i_start_req) begin
          w_iter_left_nxt   = (i_iter_count == '0) ? c_iter_one : i_iter_count;
          w_timer_nxt       = '0;
          w_tmo_err_nxt     = 1'b0;
          w_start_pulse_nxt = 1'b1;
          w_busy_nxt        = 1'b1;
          w_state_nxt       = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_done_seen) begin
          if (r_iter_left == c_iter_one) begin
            w_state_nxt      = ST_IDLE;
            w_busy_nxt       = 1'b0;
            w_done_pulse_nxt = 1'b1;
          end else begin
            w_iter_left_nxt   = r_iter_left - c_iter_one;
            w_timer_nxt       = '0;
            w_start_pulse_nxt = 1'b1;
          end
        end else if (w_timeout) begin
          w_tmo_err_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_busy_nxt    = 1'b0;
        end else if (r_timer != c_timer_max) begin
          w_timer_nxt = r_timer + c_timer_one;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_state       <= ST_IDLE;
      r_start_pulse <= 1'b0;
      r_busy        <= 1'b0;
      r_done_pulse  <= 1'b0;
      r_tmo_err     <= 1'b0;
      r_iter_left   <= '0;
      r_timer       <= '0;
    end else if (rst_sync) begin
      r_state       <= ST_IDLE;
      r_start_pulse <= 1'b0;
      r_busy        <= 1'b0;
      r_done_pulse  <= 1'b0;
      r_tmo_err     <= 1'b0;
      r_iter_left   <= '0;
      r_timer       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_pulse <= w_start_pulse_nxt;
      r_busy        <= w_busy_nxt;
      r_done_pulse  <= w_done_pulse_nxt;
      r_tmo_err     <= w_tmo_err_nxt;
      r_iter_left   <= w_iter_left_nxt;
      r_timer       <= w_timer_nxt;
    end
  end

  assign o_start_pulse = r_start_pulse;
  assign o_busy        = r_busy;
  assign o_busy_nxt    = w_busy_nxt;
  assign o_done_pulse  = r_done_pulse;
  assign o_tmo_err     = r_tmo_err;

endmodule
`default_nettype wire

// File: rtl/start_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// start_sequencer : NUM_CH independent start/done sequencers plus all_idle
// Rev 1.0
// ----------------------------------------------------------------------------
module start_sequencer
  import start_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input  logic               clk,
  input  logic               rst_async_n,
  input  logic               rst_sync,
  start_sequencer_if.slave   bus
);

  logic [NUM_CH-1:0] w_start_pulse;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_busy_nxt;
  logic [NUM_CH-1:0] w_done_pulse;
  logic [NUM_CH-1:0] w_tmo_err;
  logic              r_all_idle;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      start_seq_channel #(
        .CNT_W (CNT_W),
        .TMO_W (TMO_W)
      ) u_ch (
        .clk           (clk),
        .rst_async_n   (rst_async_n),
        .rst_sync      (rst_sync),
        .i_start_req   (bus.start_req[g]),
        .i_iter_count  (bus.iter_count),
        .i_tmo_limit   (bus.tmo_limit),
        .i_done_in     (bus.done_in[g]),
        .o_start_pulse (w_start_pulse[g]),
        .o_busy        (w_busy[g]),
        .o_busy_nxt    (w_busy_nxt[g]),
        .o_done_pulse  (w_done_pulse[g]),
        .o_tmo_err     (w_tmo_err[g])
      );
    end
  endgenerate

  // Registered from the channels' next-busy so it changes on the same edge as busy.
  always_ff @(negedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_all_idle <= 1'b1;
    end else if (rst_sync) begin
      r_all_idle <= 1'b1;
    end else begin
      r_all_idle <= ~|w_busy_nxt;
    end
  end

  assign bus.start_pulse = w_start_pulse;
  assign bus.busy        = w_busy;
  assign bus.done_pulse  = w_done_pulse;
  assign bus.tmo_err     = w_tmo_err;
  assign bus.all_idle    = r_all_idle;

endmodule
`default_nettype wire

// File: tb/tb_start_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_start_sequencer : directed + random bench with a per-channel reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_start_sequencer;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 16;
  localparam int TMO_W     = 16;
  localparam int TIMER_MAX = (1 << TMO_W) - 1;

  logic clk         = 1'b0;
  logic rst_async_n = 1'b1;
  logic rst_sync    = 1'b0;

  start_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();

  start_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .rst_sync    (rst_sync),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per channel, is a run active, launches remaining, cycles since launch.
  logic [NUM_CH-1:0] m_run, m_pulse, m_donep, m_err;
  int m_left [NUM_CH];
  int m_age  [NUM_CH];
  int cnt_sp [NUM_CH];
  int cnt_busy [NUM_CH];
  int cnt_dp [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = '0; m_pulse = '0; m_donep = '0; m_err = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_left[c] = 0;
      m_age[c]  = 0;
    end
  endtask

  task automatic model_edge();
    int lim;
    logic was_pulse;
    lim = int'(bus.tmo_limit);
    for (int c = 0; c < NUM_CH; c++) begin
      was_pulse  = m_pulse[c];
      m_pulse[c] = 1'b0;
      m_donep[c] = 1'b0;
      if (!m_run[c]) begin
        if (bus.start_req[c]) begin
          m_run[c]   = 1'b1;
          m_pulse[c] = 1'b1;
          m_err[c]   = 1'b0;
          m_age[c]   = 0;
          m_left[c]  = (bus.iter_count == '0) ? 1 : int'(bus.iter_count);
        end
      end else if (bus.done_in[c] && !was_pulse) begin
        if (m_left[c] == 1) begin
          m_run[c]   = 1'b0;
          m_donep[c] = 1'b1;
        end else begin
          m_left[c]  = m_left[c] - 1;
          m_age[c]   = 0;
          m_pulse[c] = 1'b1;
        end
      end else if (lim != 0 && m_age[c] + 1 == lim) begin
        m_err[c] = 1'b1;
        m_run[c] = 1'b0;
      end else if (m_age[c] < TIMER_MAX) begin
        m_age[c] = m_age[c] + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/start_pulse"}, 32'(bus.start_pulse), 32'(m_pulse));
    chk({tag, "/busy"},        32'(bus.busy),        32'(m_run));
    chk({tag, "/done_pulse"},  32'(bus.done_pulse),  32'(m_donep));
    chk({tag, "/tmo_err"},     32'(bus.tmo_err),     32'(m_err));
    chk({tag, "/all_idle"},    32'(bus.all_idle),    32'(~|m_run));
  endtask

  task automatic clear_cnt();
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_sp[c] = 0; cnt_busy[c] = 0; cnt_dp[c] = 0;
    end
  endtask

  // One active (falling) edge; outputs are checked half a period later.
  task automatic tick();
    @(negedge clk);
    if (!rst_async_n || rst_sync) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_sp[c]   += int'(bus.start_pulse[c]);
      cnt_busy[c] += int'(bus.busy[c]);
      cnt_dp[c]   += int'(bus.done_pulse[c]);
    end
    check_all("cyc");
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "time limit");
  end

  initial begin
    bus.start_req  = '0;
    bus.done_in    = '0;
    bus.iter_count = '0;
    bus.tmo_limit  = '0;
    model_reset();
    clear_cnt();

    // Reset state
    #2 rst_async_n = 1'b0;
    #1 check_all("reset");
    run(2);
    rst_async_n = 1'b1;
    run(1);

    // 1: single launch, done sampled 11 edges after the start edge
    bus.iter_count = 16'd1;
    clear_cnt();
    bus.start_req[0] = 1'b1; tick();
    bus.start_req[0] = 1'b0; run(10);
    bus.done_in[0] = 1'b1; tick();
    bus.done_in[0] = 1'b0; run(2);
    chk("t1_pulses", 32'(cnt_sp[0]), 32'd1);
    chk("t1_busy_cycles", 32'(cnt_busy[0]), 32'd11);
    chk("t1_done_pulses", 32'(cnt_dp[0]), 32'd1);
    chk("t1_all_idle", 32'(bus.all_idle), 32'd1);

    // 2: three iterations, iter_count changed mid-run must not matter
    bus.iter_count = 16'd3;
    clear_cnt();
    bus.start_req[1] = 1'b1; tick();
    bus.start_req[1] = 1'b0;
    bus.iter_count = 16'd7;
    for (int k = 0; k < 3; k++) begin
      run(4);
      bus.done_in[1] = 1'b1; tick();
      bus.done_in[1] = 1'b0;
    end
    run(2);
    chk("t2_pulses", 32'(cnt_sp[1]), 32'd3);
    chk("t2_done_pulses", 32'(cnt_dp[1]), 32'd1);
    bus.iter_count = 16'd0;
    clear_cnt();
    bus.start_req[1] = 1'b1; tick();
    bus.start_req[1] = 1'b0; run(3);
    bus.done_in[1] = 1'b1; tick();
    bus.done_in[1] = 1'b0; run(2);
    chk("t2_zero_pulses", 32'(cnt_sp[1]), 32'd1);
    chk("t2_zero_done", 32'(cnt_dp[1]), 32'd1);

    // 3: watchdog fires on the 8th edge after the start
    bus.iter_count = 16'd1;
    bus.tmo_limit  = 16'd8;
    bus.start_req[2] = 1'b1; tick();
    bus.start_req[2] = 1'b0; run(7);
    chk("t3_busy_before", 32'(bus.busy[2]), 32'd1);
    chk("t3_err_before", 32'(bus.tmo_err[2]), 32'd0);
    tick();
    chk("t3_err_set", 32'(bus.tmo_err[2]), 32'd1);
    chk("t3_busy_clr", 32'(bus.busy[2]), 32'd0);
    run(3);
    chk("t3_err_sticky", 32'(bus.tmo_err[2]), 32'd1);
    bus.start_req[2] = 1'b1; tick();
    bus.start_req[2] = 1'b0;
    chk("t3_err_cleared", 32'(bus.tmo_err[2]), 32'd0);
    bus.tmo_limit = 16'd0;
    run(300);
    chk("t3_no_wdog_busy", 32'(bus.busy[2]), 32'd1);
    bus.done_in[2] = 1'b1; tick();
    bus.done_in[2] = 1'b0; run(1);

    // 4: done on the exact timeout edge wins
    bus.tmo_limit = 16'd8;
    bus.start_req[3] = 1'b1; tick();
    bus.start_req[3] = 1'b0; run(7);
    bus.done_in[3] = 1'b1; tick();
    bus.done_in[3] = 1'b0;
    chk("t4_done_pulse", 32'(bus.done_pulse[3]), 32'd1);
    chk("t4_tmo_err", 32'(bus.tmo_err[3]), 32'd0);
    run(1);

    // 5: protocol corners
    bus.tmo_limit = 16'd0;
    bus.start_req[0] = 1'b1; tick();
    bus.start_req[0] = 1'b0;
    bus.done_in[0] = 1'b1; tick();
    bus.done_in[0] = 1'b0;
    chk("t5_done_in_pulse_ignored", 32'(bus.busy[0]), 32'd1);
    clear_cnt();
    bus.start_req[0] = 1'b1; run(5);
    bus.start_req[0] = 1'b0;
    chk("t5_start_in_run_ignored", 32'(cnt_sp[0]), 32'd0);
    bus.done_in[0] = 1'b1; tick();
    bus.done_in[0] = 1'b0;
    chk("t5_done_pulse", 32'(bus.done_pulse[0]), 32'd1);
    run(1);
    clear_cnt();
    bus.done_in = '1; run(3);
    bus.done_in = '0;
    for (int c = 0; c < NUM_CH; c++)
      chk("t5_idle_done_quiet", 32'(cnt_sp[c] + cnt_busy[c] + cnt_dp[c]), 32'd0);

    // 6: resets with every channel busy
    bus.iter_count = 16'd2;
    bus.start_req = '1; tick();
    bus.start_req = '0; run(3);
    chk("t6_all_busy", 32'(bus.busy), 32'hF);
    rst_sync = 1'b1; tick();
    rst_sync = 1'b0;
    chk("t6_sync_busy", 32'(bus.busy), 32'd0);
    chk("t6_sync_done", 32'(bus.done_pulse), 32'd0);
    chk("t6_sync_idle", 32'(bus.all_idle), 32'd1);
    bus.start_req = '1; tick();
    bus.start_req = '0; run(3);
    rst_async_n = 1'b0;
    #1;
    model_reset();
    check_all("async_mid_run");
    chk("t6_async_idle", 32'(bus.all_idle), 32'd1);
    run(2);
    rst_async_n = 1'b1;
    run(2);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) bus.tmo_limit = TMO_W'($urandom_range(0, 12));
      rst_sync = ($urandom_range(0, 149) == 0);
      bus.iter_count = CNT_W'($urandom_range(0, 3));
      for (int c = 0; c < NUM_CH; c++) begin
        bus.start_req[c] = ($urandom_range(0, 3) == 0);
        bus.done_in[c]   = ($urandom_range(0, 4) == 0);
      end
      tick();
    end
    rst_sync = 1'b0;
    bus.start_req = '0;
    bus.done_in = '0;
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
